// File: rtl/axi_buffer_fifo_reader_if.sv
// FIFO read port plus AXI4-Stream master bundle for the axi_buffer drain side.
// The master modport is the reader: it pops the FIFO and drives the stream.
interface axi_buffer_fifo_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int WORD_BYTES = 4
);
  logic [DATA_WIDTH-1:0]            i_fifo_data;
  logic                             i_fifo_empty;
  logic                             o_fifo_read_enable;
  logic [DATA_WIDTH*WORD_BYTES-1:0] m_axis_tdata;
  logic                             m_axis_tvalid;
  logic                             m_axis_tready;
  logic                             m_axis_tlast;

  modport master (
    input  i_fifo_data,
    input  i_fifo_empty,
    input  m_axis_tready,
    output o_fifo_read_enable,
    output m_axis_tdata,
    output m_axis_tvalid,
    output m_axis_tlast
  );

  modport slave (
    output i_fifo_data,
    output i_fifo_empty,
    output m_axis_tready,
    input  o_fifo_read_enable,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    input  m_axis_tlast
  );
endinterface

// File: rtl/axi_buffer_fifo_reader.sv
// Packs WORD_BYTES show-ahead FIFO entries (little-endian) into one stream word per FILL/SEND round.
// Word valid the cycle after its last pop; a stalled word holds tdata/tlast and pauses all popping.
module axi_buffer_fifo_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int WORD_BYTES = 4,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_start,
  input  logic [LEN_WIDTH-1:0] i_length,
  output logic                 o_busy,
  output logic                 o_done,
  axi_buffer_fifo_reader_if.master bus
);

  localparam int LANE_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WORD_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    SEND = 2'd2
  } state_e;

  state_e                           state_q, state_d;
  logic [LANE_W-1:0]                lane_q, lane_d;
  logic [LEN_WIDTH-1:0]             word_q, word_d;
  logic [LEN_WIDTH-1:0]             len_q, len_d;
  logic [DATA_WIDTH*WORD_BYTES-1:0] data_q, data_d;
  logic                             done_q, done_d;

  logic pop;
  logic send;
  logic last;

  assign pop  = (state_q == FILL) && !bus.i_fifo_empty;
  assign send = (state_q == SEND);
  assign last = send && (word_q == (len_q - LEN_WIDTH'(1)));

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    word_d  = word_q;
    len_d   = len_q;
    data_d  = data_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          len_d = i_length;
          if (i_length == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = FILL;
            lane_d  = '0;
            word_d  = '0;
          end
        end
      end

      FILL: begin
        if (pop) begin
          for (int l = 0; l < WORD_BYTES; l++) begin
            if (lane_q == LANE_W'(l)) begin
              data_d[l*DATA_WIDTH +: DATA_WIDTH] = bus.i_fifo_data;
            end
          end
          if (lane_q == LAST_LANE) begin
            lane_d  = '0;
            state_d = SEND;
          end else begin
            lane_d = lane_q + LANE_W'(1);
          end
        end
      end

      SEND: begin
        if (bus.m_axis_tready) begin
          word_d  = word_q + LEN_WIDTH'(1);
          state_d = last ? IDLE : FILL;
          done_d  = last;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset drops any partially assembled word; FIFO entries already popped are lost by design.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      lane_q  <= '0;
      word_q  <= '0;
      len_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      len_q   <= len_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign bus.o_fifo_read_enable = pop;
  assign bus.m_axis_tvalid      = send;
  assign bus.m_axis_tlast       = last;
  assign bus.m_axis_tdata       = data_q;
  assign o_busy                 = (state_q != IDLE);
  assign o_done                 = done_q;

endmodule

// File: tb/tb_axi_buffer_fifo_reader.sv
// Randomized and directed bench for axi_buffer_fifo_reader against a transaction-level model
// (byte queue in, words out, busy/done timing derived from counts of bytes and words).
module tb_axi_buffer_fifo_reader;
  localparam int DW = 8;
  localparam int WB = 4;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_start;
  logic [LW-1:0] i_length;
  logic          o_busy;
  logic          o_done;

  axi_buffer_fifo_reader_if #(.DATA_WIDTH(DW), .WORD_BYTES(WB)) bus ();

  axi_buffer_fifo_reader #(.DATA_WIDTH(DW), .WORD_BYTES(WB), .LEN_WIDTH(LW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_start  (i_start),
    .i_length (i_length),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  byte unsigned fifo_q[$];
  bit           gate_empty;
  bit           rand_mode;

  // Reference model state
  bit           m_busy;
  bit           m_done;
  int           m_len;
  int           m_sent;
  byte unsigned m_bytes[$];

  logic [31:0]  words_seen[$];
  bit           lasts_seen[$];
  int           pops_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_fifo();
    bus.i_fifo_empty = gate_empty || (fifo_q.size() == 0);
    bus.i_fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic clear_obs();
    words_seen.delete();
    lasts_seen.delete();
    pops_seen = 0;
  endtask

  function automatic logic [31:0] word_at(input int i);
    if (i < words_seen.size()) return words_seen[i];
    return 32'hxxxxxxxx;
  endfunction

  function automatic logic [31:0] last_at(input int i);
    if (i < lasts_seen.size()) return {31'd0, lasts_seen[i]};
    return 32'hxxxxxxxx;
  endfunction

  // One clock: entered and left at posedge+1.
  task automatic cycle();
    bit          exp_re, exp_vld, exp_last, hs, re_obs;
    logic [31:0] exp_dat;
    if (rand_mode) begin
      bus.m_axis_tready = ($urandom_range(0, 3) != 0);
      gate_empty        = ($urandom_range(0, 4) == 0);
      if (m_busy) begin
        i_start  = ($urandom_range(0, 5) == 0);
        i_length = LW'($urandom_range(0, 7));
      end
    end
    drive_fifo();
    @(negedge clk);
    exp_re   = m_busy && (m_bytes.size() < WB) && !bus.i_fifo_empty;
    exp_vld  = m_busy && (m_bytes.size() == WB);
    exp_last = exp_vld && (m_sent == m_len - 1);
    chk("busy",   {31'd0, o_busy},                 {31'd0, m_busy});
    chk("done",   {31'd0, o_done},                 {31'd0, m_done});
    chk("rd_en",  {31'd0, bus.o_fifo_read_enable}, {31'd0, exp_re});
    chk("tvalid", {31'd0, bus.m_axis_tvalid},      {31'd0, exp_vld});
    chk("tlast",  {31'd0, bus.m_axis_tlast},       {31'd0, exp_last});
    if (exp_vld) begin
      exp_dat = '0;
      for (int i = 0; i < WB; i++) exp_dat[i*DW +: DW] = m_bytes[i];
      chk("tdata", bus.m_axis_tdata, exp_dat);
    end
    re_obs = bus.o_fifo_read_enable;
    if (re_obs) pops_seen++;
    if (bus.m_axis_tvalid && bus.m_axis_tready) begin
      words_seen.push_back(bus.m_axis_tdata);
      lasts_seen.push_back(bus.m_axis_tlast);
    end
    hs     = exp_vld && bus.m_axis_tready;
    m_done = 1'b0;
    if (!m_busy && i_start) begin
      if (i_length == '0) begin
        m_done = 1'b1;
      end else begin
        m_busy = 1'b1;
        m_len  = int'(i_length);
        m_sent = 0;
        m_bytes.delete();
      end
    end
    if (exp_re) m_bytes.push_back(fifo_q[0]);
    if (hs) begin
      m_sent++;
      m_bytes.delete();
      if (m_sent == m_len) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (re_obs && fifo_q.size() != 0) void'(fifo_q.pop_front());
    i_start = 1'b0;
    drive_fifo();
  endtask

  task automatic run_until_idle(input int budget, input string tag);
    int n = 0;
    while ((m_busy || m_done) && n < budget) begin
      cycle();
      n++;
    end
    if (n >= budget) chk({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic start(input int len);
    i_length = LW'(len);
    i_start  = 1'b1;
    cycle();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"},   {31'd0, o_busy},                 32'd0);
    chk({tag, "_done"},   {31'd0, o_done},                 32'd0);
    chk({tag, "_rd_en"},  {31'd0, bus.o_fifo_read_enable}, 32'd0);
    chk({tag, "_tvalid"}, {31'd0, bus.m_axis_tvalid},      32'd0);
    chk({tag, "_tlast"},  {31'd0, bus.m_axis_tlast},       32'd0);
    chk({tag, "_tdata"},  bus.m_axis_tdata,                32'd0);
  endtask

  logic [31:0] exp_w;

  initial begin
    reset_n           = 1'b0;
    i_start           = 1'b0;
    i_length          = '0;
    bus.m_axis_tready = 1'b1;
    gate_empty        = 1'b0;
    rand_mode         = 1'b0;
    m_busy = 1'b0; m_done = 1'b0; m_len = 0; m_sent = 0;
    drive_fifo();
    #12;
    check_outputs_zero("reset");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic two-word transfer
    fifo_q.delete();
    for (int i = 1; i <= 8; i++) fifo_q.push_back(byte'(i));
    clear_obs();
    start(2);
    run_until_idle(40, "t1");
    chk("t1_nwords", words_seen.size(), 32'd2);
    chk("t1_w0", word_at(0), 32'h04030201);
    chk("t1_l0", last_at(0), 32'd0);
    chk("t1_w1", word_at(1), 32'h08070605);
    chk("t1_l1", last_at(1), 32'd1);
    chk("t1_pops", pops_seen, 32'd8);

    // Backpressure: five stalled cycles with tvalid high
    fifo_q.delete();
    for (int i = 0; i < 8; i++) fifo_q.push_back(byte'($urandom_range(0, 255)));
    exp_w = {fifo_q[3], fifo_q[2], fifo_q[1], fifo_q[0]};
    clear_obs();
    bus.m_axis_tready = 1'b0;
    start(1);
    for (int i = 0; i < 4; i++) cycle();
    for (int i = 0; i < 5; i++) cycle();
    chk("t2_pops_stalled", pops_seen, 32'd4);
    chk("t2_nwords_stalled", words_seen.size(), 32'd0);
    bus.m_axis_tready = 1'b1;
    run_until_idle(20, "t2");
    chk("t2_w0", word_at(0), exp_w);
    chk("t2_l0", last_at(0), 32'd1);

    // FIFO underrun mid-word, refilled three cycles later
    fifo_q.delete();
    fifo_q.push_back(8'hA1);
    fifo_q.push_back(8'hB2);
    clear_obs();
    start(1);
    for (int i = 0; i < 2; i++) cycle();
    for (int i = 0; i < 3; i++) cycle();
    chk("t3_pops_empty", pops_seen, 32'd2);
    fifo_q.push_back(8'hC3);
    fifo_q.push_back(8'hD4);
    run_until_idle(20, "t3");
    chk("t3_w0", word_at(0), 32'hD4C3B2A1);
    chk("t3_l0", last_at(0), 32'd1);

    // Zero-length start
    fifo_q.delete();
    fifo_q.push_back(8'h55);
    clear_obs();
    start(0);
    cycle();
    cycle();
    chk("t4_pops", pops_seen, 32'd0);
    chk("t4_nwords", words_seen.size(), 32'd0);

    // Start while busy is ignored
    fifo_q.delete();
    for (int i = 0; i < 8; i++) fifo_q.push_back(byte'(8'h10 + i));
    clear_obs();
    start(2);
    cycle();
    start(1);
    run_until_idle(40, "t5a");
    chk("t5a_nwords", words_seen.size(), 32'd2);
    chk("t5a_l0", last_at(0), 32'd0);
    chk("t5a_l1", last_at(1), 32'd1);

    // Reset in the middle of FILL, then a fresh one-word transfer
    fifo_q.delete();
    for (int i = 0; i < 8; i++) fifo_q.push_back(byte'(8'h30 + i));
    clear_obs();
    start(3);
    cycle();
    cycle();
    reset_n = 1'b0;
    #1;
    check_outputs_zero("t5b_rst");
    m_busy = 1'b0; m_done = 1'b0; m_bytes.delete();
    #2;
    reset_n = 1'b1;
    exp_w = {fifo_q[3], fifo_q[2], fifo_q[1], fifo_q[0]};
    clear_obs();
    start(1);
    run_until_idle(20, "t5b");
    chk("t5b_w0", word_at(0), exp_w);
    chk("t5b_l0", last_at(0), 32'd1);

    // Back-to-back: new start in the o_done cycle
    fifo_q.delete();
    for (int i = 0; i < 8; i++) fifo_q.push_back(byte'(8'h60 + i));
    clear_obs();
    start(1);
    begin
      int n = 0;
      while (!m_done && n < 20) begin
        cycle();
        n++;
      end
      if (n >= 20) chk("t6_timeout", 32'd1, 32'd0);
    end
    chk("t6_done_now", {31'd0, o_done}, 32'd1);
    start(1);
    chk("t6_busy_after", {31'd0, o_busy}, 32'd1);
    run_until_idle(20, "t6");
    chk("t6_nwords", words_seen.size(), 32'd2);
    chk("t6_w1", word_at(1), 32'h67666564);
    chk("t6_l1", last_at(1), 32'd1);

    // Randomized transfers with random backpressure, FIFO gaps and stray starts
    rand_mode = 1'b1;
    for (int t = 0; t < 25; t++) begin
      int len;
      len = $urandom_range(0, 5);
      fifo_q.delete();
      for (int i = 0; i < len * WB; i++) fifo_q.push_back(byte'($urandom_range(0, 255)));
      clear_obs();
      start(len);
      run_until_idle(400, "rand");
      chk("rand_nwords", words_seen.size(), len);
      chk("rand_pops", pops_seen, len * WB);
    end
    rand_mode = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
